// File: rtl/mod_n_stream.sv
// Serial MSB-first divisibility tester: tracks the running remainder of a framed
// bit stream modulo DIVISOR and reports the verdict and length of each completed frame.
module mod_n_stream #(
    parameter int DIVISOR = 3,
    parameter int CNT_W   = 16,
    localparam int REM_W  = ($clog2(DIVISOR) > 1) ? $clog2(DIVISOR) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic             x_i,
    input  logic             sof_i,
    input  logic             eof_i,
    output logic             div_o,
    output logic [REM_W-1:0] rem_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             result_o,
    output logic [CNT_W-1:0] len_o
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [REM_W:0]   DIV_L   = (REM_W+1)'(DIVISOR);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               result_q, result_d;
    logic [CNT_W-1:0]   len_q, len_d;

    logic               accept;
    logic [REM_W-1:0]   base;
    logic [REM_W:0]     sum;
    logic [REM_W-1:0]   rem_next;
    logic [CNT_W-1:0]   cnt_next;

    // base < DIVISOR, so 2*base+x < 2*DIVISOR and one conditional subtract reduces it.
    always_comb begin
        accept   = valid_i && ((state_q == ACTIVE) || sof_i);
        base     = sof_i ? '0 : rem_q;
        sum      = {base, x_i};
        rem_next = (sum >= DIV_L) ? REM_W'(sum - DIV_L) : REM_W'(sum);
        if (sof_i)
            cnt_next = CNT_W'(1);
        else if (cnt_q == CNT_MAX)
            cnt_next = cnt_q;
        else
            cnt_next = cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        len_d    = len_q;
        if (accept) begin
            rem_d = rem_next;
            cnt_d = cnt_next;
            if (eof_i) begin
                state_d  = IDLE;
                done_d   = 1'b1;
                result_d = (rem_next == '0);
                len_d    = cnt_next;
            end else begin
                state_d = ACTIVE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= 1'b0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            len_q    <= len_d;
        end
    end

    assign div_o    = accept ? (rem_next == '0) : (rem_q == '0);
    assign rem_o    = rem_q;
    assign busy_o   = (state_q == ACTIVE);
    assign done_o   = done_q;
    assign result_o = result_q;
    assign len_o    = len_q;
endmodule

// File: tb/tb_mod_n_stream.sv
// Bench for mod_n_stream: four instances (DIVISOR 3/5/7, plus a 4-bit counter
// variant) share one input stream and are compared against a frame-value model.
module tb_mod_n_stream;
    logic clk = 1'b0;
    logic reset, valid, x, sof, eof;

    always #5 clk = ~clk;

    logic       div3, div5, div7, div3s;
    logic [1:0] rem3, rem3s;
    logic [2:0] rem5, rem7;
    logic       busy3, busy5, busy7, busy3s;
    logic       done3, done5, done7, done3s;
    logic       res3, res5, res7, res3s;
    logic [15:0] len3, len5, len7;
    logic [3:0]  len3s;

    mod_n_stream #(.DIVISOR(3), .CNT_W(16)) u3 (
        .clk(clk), .reset(reset), .valid_i(valid), .x_i(x), .sof_i(sof), .eof_i(eof),
        .div_o(div3), .rem_o(rem3), .busy_o(busy3), .done_o(done3), .result_o(res3), .len_o(len3));
    mod_n_stream #(.DIVISOR(5), .CNT_W(16)) u5 (
        .clk(clk), .reset(reset), .valid_i(valid), .x_i(x), .sof_i(sof), .eof_i(eof),
        .div_o(div5), .rem_o(rem5), .busy_o(busy5), .done_o(done5), .result_o(res5), .len_o(len5));
    mod_n_stream #(.DIVISOR(7), .CNT_W(16)) u7 (
        .clk(clk), .reset(reset), .valid_i(valid), .x_i(x), .sof_i(sof), .eof_i(eof),
        .div_o(div7), .rem_o(rem7), .busy_o(busy7), .done_o(done7), .result_o(res7), .len_o(len7));
    mod_n_stream #(.DIVISOR(3), .CNT_W(4)) u3s (
        .clk(clk), .reset(reset), .valid_i(valid), .x_i(x), .sof_i(sof), .eof_i(eof),
        .div_o(div3s), .rem_o(rem3s), .busy_o(busy3s), .done_o(done3s), .result_o(res3s), .len_o(len3s));

    logic [31:0] div_a[4], rem_a[4], busy_a[4], done_a[4], res_a[4], len_a[4];
    assign div_a  = '{32'(div3),  32'(div5),  32'(div7),  32'(div3s)};
    assign rem_a  = '{32'(rem3),  32'(rem5),  32'(rem7),  32'(rem3s)};
    assign busy_a = '{32'(busy3), 32'(busy5), 32'(busy7), 32'(busy3s)};
    assign done_a = '{32'(done3), 32'(done5), 32'(done7), 32'(done3s)};
    assign res_a  = '{32'(res3),  32'(res5),  32'(res7),  32'(res3s)};
    assign len_a  = '{32'(len3),  32'(len5),  32'(len7),  32'(len3s)};

    int unsigned divs[4] = '{3, 5, 7, 3};
    int unsigned lmax[4] = '{65535, 65535, 65535, 15};

    // Reference model: the frame is held as its integer value and bit count.
    logic        m_open;
    logic [63:0] m_val;
    int unsigned m_n;
    logic        m_done, m_fin_ok;
    logic [63:0] m_fin_val;
    int unsigned m_fin_n;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rem[%0d]", i), rem_a[i], 32'(m_val % 64'(divs[i])));
            chk($sformatf("busy[%0d]", i), busy_a[i], 32'(m_open));
            chk($sformatf("done[%0d]", i), done_a[i], 32'(m_done));
            chk($sformatf("result[%0d]", i), res_a[i],
                32'(m_fin_ok && ((m_fin_val % 64'(divs[i])) == 64'd0)));
            chk($sformatf("len[%0d]", i), len_a[i],
                m_fin_ok ? ((m_fin_n > lmax[i]) ? lmax[i] : m_fin_n) : 32'd0);
        end
    endtask

    task automatic cyc(input logic v, input logic xb, input logic s, input logic e, input logic r);
        logic        acc;
        logic [63:0] nv;
        valid = v; x = xb; sof = s; eof = e; reset = r;
        @(negedge clk);
        acc = v && (m_open || s);
        nv  = ((s ? 64'd0 : m_val) << 1) + 64'(xb);
        if (!r)
            for (int i = 0; i < 4; i++)
                chk($sformatf("div[%0d]", i), div_a[i],
                    32'(acc ? ((nv % 64'(divs[i])) == 64'd0) : ((m_val % 64'(divs[i])) == 64'd0)));
        if (r) begin
            m_open = 1'b0; m_val = '0; m_n = 0; m_done = 1'b0;
            m_fin_ok = 1'b0; m_fin_val = '0; m_fin_n = 0;
        end else begin
            m_done = 1'b0;
            if (acc) begin
                m_val = nv;
                m_n   = s ? 1 : m_n + 1;
                if (e) begin
                    m_done = 1'b1; m_fin_ok = 1'b1; m_fin_val = nv; m_fin_n = m_n;
                    m_open = 1'b0;
                end else begin
                    m_open = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        m_open = 1'b0; m_val = '0; m_n = 0; m_done = 1'b0;
        m_fin_ok = 1'b0; m_fin_val = '0; m_fin_n = 0;
        // Reset wins over a simultaneous sof/eof bit.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_div3", 32'(div3), 32'd1);
        gap(1);

        // Value 6 mod 3, consecutive bits.
        cyc(1, 1, 1, 0, 0);
        chk("v6_rem0", 32'(rem3), 32'd1);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        chk("v6_done", 32'(done3), 32'd1);
        chk("v6_result", 32'(res3), 32'd1);
        chk("v6_len", 32'(len3), 32'd3);
        gap(1);

        // Value 7 mod 3 with two-cycle gaps.
        cyc(1, 0, 1, 0, 0); gap(2);
        cyc(1, 1, 0, 0, 0); gap(2);
        cyc(1, 1, 0, 0, 0); gap(2);
        cyc(1, 1, 0, 1, 0);
        chk("v7_result", 32'(res3), 32'd0);
        chk("v7_len", 32'(len3), 32'd4);
        gap(1);

        // Value 10 then back-to-back value 3 (checked on DIVISOR 5).
        cyc(1, 1, 1, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 1, 0);
        chk("v10_result5", 32'(res5), 32'd1);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 0, 1, 0);
        chk("v3_result5", 32'(res5), 32'd0);
        chk("v3_len5", 32'(len5), 32'd2);
        gap(1);

        // One-bit frame.
        cyc(1, 0, 1, 1, 0);
        chk("one_bit_done", 32'(done3), 32'd1);
        chk("one_bit_busy", 32'(busy3), 32'd0);
        chk("one_bit_len", 32'(len3), 32'd1);
        gap(1);

        // Abort by sof restart, then value 9.
        cyc(1, 1, 1, 0, 0); cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        chk("restart_no_done", 32'(done3), 32'd0);
        cyc(1, 1, 0, 1, 0);
        chk("v9_result", 32'(res3), 32'd1);
        chk("v9_len", 32'(len3), 32'd4);

        // Reset mid-frame, then idle non-sof bits are ignored.
        cyc(1, 1, 1, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 1, 1);
        for (int i = 0; i < 4; i++) cyc(1, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 0);
        chk("idle_ignored_len7", 32'(len7), 32'd0);
        chk("idle_ignored_rem7", 32'(rem7), 32'd0);

        // Length saturation on the 4-bit counter instance.
        cyc(1, 1, 1, 0, 0);
        for (int i = 0; i < 18; i++) cyc(1, 1'($urandom_range(0, 1)), 0, 0, 0);
        cyc(1, 1, 0, 1, 0);
        chk("sat_len4", 32'(len3s), 32'd15);
        chk("sat_len16", 32'(len3), 32'd20);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            logic v, xb, s, e, r;
            v  = ($urandom_range(0, 99) < 70);
            xb = 1'($urandom_range(0, 1));
            s  = m_open ? ($urandom_range(0, 99) < 4) : ($urandom_range(0, 99) < 30);
            e  = ($urandom_range(0, 99) < 15);
            r  = ($urandom_range(0, 199) == 0);
            if (m_open && m_n >= 38) begin
                v = 1'b1; s = 1'b0; e = 1'b1;
            end
            cyc(v, xb, s, e, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
